// File: rtl/formula_2_distributor_if.sv
// Handshake bundle between the upstream dispatcher, formula_2_distributor and its
// N_UNITS formula units. The distributor takes the slave view and the environment takes the master view.
interface formula_2_distributor_if #(parameter int N_UNITS = 4);
  logic                   arg_vld;
  logic [31:0]            a;
  logic [31:0]            b;
  logic [31:0]            c;
  logic                   arg_rdy;
  logic                   res_vld;
  logic [31:0]            res;
  logic                   err;
  logic [N_UNITS-1:0]     unit_arg_vld;
  logic [31:0]            unit_a;
  logic [31:0]            unit_b;
  logic [31:0]            unit_c;
  logic [N_UNITS-1:0]     unit_res_vld;
  logic [N_UNITS*32-1:0]  unit_res;

  modport slave (
    input  arg_vld, a, b, c, unit_res_vld, unit_res,
    output arg_rdy, res_vld, res, err, unit_arg_vld, unit_a, unit_b, unit_c
  );

  modport master (
    output arg_vld, a, b, c, unit_res_vld, unit_res,
    input  arg_rdy, res_vld, res, err, unit_arg_vld, unit_a, unit_b, unit_c
  );
endinterface

// File: rtl/formula_2_distributor.sv
// Round-robin dispatcher over N_UNITS serial formula units with in-order result emission.
// Define FORMULA_2_DISTRIBUTOR_CHECK_EN to enable the sticky err flag for unexpected unit results.
module formula_2_distributor #(
    parameter int N_UNITS = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    formula_2_distributor_if.slave bus
);
    localparam int PW = $clog2(N_UNITS);
    typedef logic [PW-1:0] ptr_t;

    ptr_t               wr_ptr;
    ptr_t               rd_ptr;
    logic [N_UNITS-1:0] busy;
    logic [N_UNITS-1:0] buf_vld;
    logic [N_UNITS-1:0] cap;
    logic [31:0]        res_buf [N_UNITS];
    logic               dispatch;
    logic               emit;

    // A unit stays busy until its result has left, so ready depends on registers only.
    assign bus.arg_rdy = !busy[wr_ptr];
    assign dispatch    = bus.arg_vld && !busy[wr_ptr];
    assign emit        = buf_vld[rd_ptr];

    assign bus.unit_a  = bus.a;
    assign bus.unit_b  = bus.b;
    assign bus.unit_c  = bus.c;

    always_comb begin
        bus.unit_arg_vld = '0;
        if (dispatch) bus.unit_arg_vld[wr_ptr] = 1'b1;
    end

    // Results from idle units or into an already full slot are dropped.
    assign cap = bus.unit_res_vld & busy & ~buf_vld;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= '0;
            buf_vld     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bus.res_vld <= 1'b0;
            bus.res     <= '0;
        end else begin
            buf_vld <= buf_vld | cap;
            if (dispatch) begin
                busy[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + ptr_t'(1);
            end
            bus.res_vld <= emit;
            if (emit) begin
                buf_vld[rd_ptr] <= 1'b0;
                busy[rd_ptr]    <= 1'b0;
                rd_ptr          <= rd_ptr + ptr_t'(1);
                bus.res         <= res_buf[rd_ptr];
            end
        end
    end

    // NOTE: the result buffers carry no reset; buf_vld alone qualifies their contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_UNITS; k++) begin
            if (cap[k]) res_buf[k] <= bus.unit_res[k*32 +: 32];
        end
    end

`ifdef FORMULA_2_DISTRIBUTOR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (|(bus.unit_res_vld & (~busy | buf_vld))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_formula_2_distributor.sv
// Randomized and directed bench for formula_2_distributor: stub units with programmable latency
// feed a queue-based in-order model that is compared against the DUT every cycle.
module tb_formula_2_distributor;
    localparam int N = 4;

`ifdef FORMULA_2_DISTRIBUTOR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    formula_2_distributor_if #(.N_UNITS(N)) bus ();

    formula_2_distributor #(.N_UNITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: expected results in acceptance order, count of units in flight.
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_cyc[$];
    int          outstanding;
    int          acc_cnt;
    int          cyc;
    logic [31:0] last_res;
    logic        err_model;
    bit          cmp_en;
    bit          accepted;
    logic [N-1:0] last_uv;

    // Stub units.
    int          stub_cnt [N];
    logic [31:0] stub_val [N];
    int          lat_fixed [N];
    bit          lat_directed;
    int          lat_max;
    logic [N-1:0] inj_mask;
    logic [N-1:0] inj_driven;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r;
        longint t;
        r = 0;
        for (int i = 20; i >= 0; i--) begin
            t = r | (longint'(1) << i);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] formula(input logic [31:0] fa, input logic [31:0] fb, input logic [31:0] fc);
        longint t;
        t = isqrt(longint'(fc));
        t = isqrt(longint'(fb) + t);
        t = isqrt(longint'(fa) + t);
        return t[31:0];
    endfunction

    task automatic compare();
        logic [N-1:0] exp_uv;
        accepted = 1'b0;
        if (bus.res_vld) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL res_unexpected: got res_vld=1 res=%0h, expected no result (cycle %0d)", bus.res, cyc);
            end else begin
                check("res", bus.res, exp_q.pop_front());
                outstanding--;
            end
            got_q.push_back(bus.res);
            got_cyc.push_back(cyc);
            last_res = bus.res;
        end else begin
            check("res_hold", bus.res, last_res);
        end
        check("arg_rdy", 32'(bus.arg_rdy), 32'(outstanding < N));
        exp_uv = '0;
        if (bus.arg_vld && outstanding < N) exp_uv[acc_cnt % N] = 1'b1;
        check("unit_arg_vld", 32'(bus.unit_arg_vld), 32'(exp_uv));
        check("unit_a", bus.unit_a, bus.a);
        check("unit_c", bus.unit_c, bus.c);
        check("err", 32'(bus.err), 32'(err_model));
        if (bus.arg_vld && outstanding < N) begin
            exp_q.push_back(formula(bus.a, bus.b, bus.c));
            outstanding++;
            acc_cnt++;
            accepted = 1'b1;
            last_uv  = bus.unit_arg_vld;
        end
        if (|inj_driven) err_model = err_model | CHECK;
        for (int k = 0; k < N; k++) begin
            if (bus.unit_arg_vld[k]) begin
                stub_cnt[k] = lat_directed ? lat_fixed[k] : int'($urandom_range(1, lat_max));
                stub_val[k] = formula(bus.unit_a, bus.unit_b, bus.unit_c);
            end
        end
    endtask

    task automatic step();
        logic [N-1:0]   v;
        logic [N*32-1:0] r;
        @(negedge clk);
        if (cmp_en) compare();
        @(posedge clk);
        #1;
        cyc++;
        v = '0;
        r = bus.unit_res;
        for (int k = 0; k < N; k++) begin
            if (stub_cnt[k] > 0) begin
                stub_cnt[k]--;
                if (stub_cnt[k] == 0) begin
                    v[k]          = 1'b1;
                    r[k*32 +: 32] = stub_val[k];
                end
            end
            if (inj_mask[k]) begin
                v[k]          = 1'b1;
                r[k*32 +: 32] = 32'hdead_beef;
            end
        end
        inj_driven       = inj_mask;
        inj_mask         = '0;
        bus.unit_res_vld = v;
        bus.unit_res     = r;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        bus.arg_vld = 1'b0;
        cmp_en      = 1'b0;
        inj_mask    = '0;
        for (int k = 0; k < N; k++) stub_cnt[k] = 0;
        step();
        rst_n       = 1'b1;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        outstanding = 0;
        acc_cnt     = 0;
        last_res    = '0;
        err_model   = 1'b0;
        inj_driven  = '0;
        cmp_en      = 1'b1;
    endtask

    task automatic send_arg(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc, output int waited);
        bus.arg_vld = 1'b1;
        bus.a = va;
        bus.b = vb;
        bus.c = vc;
        waited = 0;
        step();
        while (!accepted && waited < 200) begin
            waited++;
            step();
        end
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: argument not accepted after %0d cycles, expected acceptance", waited);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.arg_vld = 1'b0;
        while ((exp_q.size() > 0) && n < 500) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        repeat (3) step();
    endtask

    initial begin
        int w;
        bus.arg_vld = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        bus.unit_res_vld = '0;
        bus.unit_res = '0;
        cyc = 0;
        lat_directed = 1'b0;
        lat_max = 5;
        last_uv = '0;
        for (int k = 0; k < N; k++) lat_fixed[k] = 1;

        // Pin the reference formula with hand-computed values.
        check("pin_0_0_16", formula(32'd0, 32'd0, 32'd16), 32'd1);
        check("pin_1_2_4", formula(32'd1, 32'd2, 32'd4), 32'd1);
        check("pin_14_7_81", formula(32'd14, 32'd7, 32'd81), 32'd4);
        check("pin_100_0_0", formula(32'd100, 32'd0, 32'd0), 32'd10);

        // Reset state.
        apply_reset();
        check("rst_arg_rdy", 32'(bus.arg_rdy), 32'd1);
        check("rst_res_vld", 32'(bus.res_vld), 32'd0);
        check("rst_res", bus.res, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        // Single argument.
        send_arg(32'd0, 32'd0, 32'd16, w);
        drain();
        check("single_count", got_q.size(), 32'd1);
        if (got_q.size() > 0) check("single_res", got_q[0], 32'd1);

        // Four back-to-back arguments.
        apply_reset();
        lat_directed = 1'b1;
        for (int k = 0; k < N; k++) lat_fixed[k] = 8;
        send_arg(32'd1, 32'd2, 32'd4, w);
        send_arg(32'd14, 32'd7, 32'd81, w);
        send_arg(32'd100, 32'd0, 32'd0, w);
        send_arg(32'd0, 32'd0, 32'd16, w);
        drain();
        check("b2b_count", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            check("b2b_res0", got_q[0], 32'd1);
            check("b2b_res1", got_q[1], 32'd4);
            check("b2b_res2", got_q[2], 32'd10);
            check("b2b_res3", got_q[3], 32'd1);
        end

        // Fifth argument while full: stalls, then wraps to unit 0.
        apply_reset();
        for (int k = 0; k < N; k++) lat_fixed[k] = 20;
        for (int i = 0; i < 4; i++) send_arg(32'(i), 32'(i + 1), 32'(i * 9), w);
        send_arg(32'd50, 32'd60, 32'd70, w);
        check("fifth_stalled", 32'(w > 10), 32'd1);
        check("fifth_unit", 32'(last_uv), 32'd1);
        drain();

        // Out-of-order completion: unit 1 finishes before unit 0.
        apply_reset();
        lat_fixed[0] = 6;
        lat_fixed[1] = 2;
        send_arg(32'd100, 32'd0, 32'd0, w);
        send_arg(32'd14, 32'd7, 32'd81, w);
        drain();
        check("ooo_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("ooo_res0", got_q[0], 32'd10);
            check("ooo_res1", got_q[1], 32'd4);
            check("ooo_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
        end

        // Reset with three units busy discards everything.
        apply_reset();
        for (int k = 0; k < N; k++) lat_fixed[k] = 30;
        for (int i = 0; i < 3; i++) send_arg(32'(i + 7), 32'd3, 32'd5, w);
        bus.arg_vld = 1'b0;
        repeat (2) step();
        apply_reset();
        check("midrst_arg_rdy", 32'(bus.arg_rdy), 32'd1);
        check("midrst_res_vld", 32'(bus.res_vld), 32'd0);
        repeat (40) step();
        check("midrst_no_stale", got_q.size(), 32'd0);

        // Stray result from an idle unit.
        inj_mask = 4'b0100;
        repeat (6) step();
        check("inject_err", 32'(bus.err), 32'(CHECK));
        check("inject_no_res", got_q.size(), 32'd0);
        apply_reset();
        check("inject_err_cleared", 32'(bus.err), 32'd0);

        // Randomized traffic with random unit latencies.
        lat_directed = 1'b0;
        lat_max = 12;
        for (int i = 0; i < 3000; i++) begin
            if (!(bus.arg_vld && !accepted)) begin
                bus.arg_vld = ($urandom_range(0, 99) < 60);
                bus.a = $urandom & 32'h3fff_ffff;
                bus.b = $urandom & 32'h3fff_ffff;
                bus.c = $urandom & 32'h3fff_ffff;
            end
            step();
        end
        drain();
        check("rand_all_done", 32'(outstanding), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
